// File: rtl/muldiv_ctl_if.sv
// Pipeline-to-HI/LO-sequencer bundle: D/E instructions in, start/commit/stall controls out.
// master = pipeline side driving instructions, slave = muldiv_ctl.
interface muldiv_ctl_if;
  logic [31:0] instrD;
  logic [31:0] instrE;
  logic        enE;
  logic        md_start;
  logic [1:0]  md_op;
  logic        md_busy;
  logic        hilo_we;
  logic        mthi_we;
  logic        mtlo_we;
  logic        stall_md;

  modport master (
    output instrD, instrE, enE,
    input  md_start, md_op, md_busy, hilo_we, mthi_we, mtlo_we, stall_md
  );

  modport slave (
    input  instrD, instrE, enE,
    output md_start, md_op, md_busy, hilo_we, mthi_we, mtlo_we, stall_md
  );
endinterface

// File: rtl/muldiv_ctl.sv
// Sequencer for an iterative mult/div HI/LO unit: start pulse in E, commit N cycles later.
// Latency MULT_CYCLES/DIV_CYCLES; stalls D on any HI/LO access while the unit is occupied.
module muldiv_ctl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_ctl_if.slave   bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [5:0] funct_e, funct_d;
  logic       special_e, special_d;
  logic       md_class_e, hilo_class_d;
  logic       is_mthi_e, is_mtlo_e;
  logic       start, busy;

  always_comb begin
    special_e    = (bus.instrE[31:26] == 6'd0);
    special_d    = (bus.instrD[31:26] == 6'd0);
    funct_e      = bus.instrE[5:0];
    funct_d      = bus.instrD[5:0];
    // 0x18..0x1B are the mult/div group, 0x10..0x13 the HI/LO moves
    md_class_e   = special_e && (funct_e[5:2] == 4'b0110);
    hilo_class_d = special_d && ((funct_d[5:2] == 4'b0110) || (funct_d[5:2] == 4'b0100));
    is_mthi_e    = special_e && (funct_e == 6'h11);
    is_mtlo_e    = special_e && (funct_e == 6'h13);
  end

  // rst_n gates the combinational outputs so they read 0 for the whole reset window
  assign start = rst_n && bus.enE && md_class_e && (state_q == S_IDLE);
  assign busy  = rst_n && (start || (state_q == S_BUSY));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_BUSY;
        cnt_d   = funct_e[1] ? DIV_LOAD : MULT_LOAD;
      end
    end else begin
      if (cnt_q == 4'd0) begin
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.md_start = start;
  assign bus.md_op    = start ? funct_e[1:0] : 2'b00;
  assign bus.md_busy  = busy;
  assign bus.hilo_we  = rst_n && (state_q == S_BUSY) && (cnt_q == 4'd0);
  assign bus.mthi_we  = rst_n && bus.enE && is_mthi_e && !busy;
  assign bus.mtlo_we  = rst_n && bus.enE && is_mtlo_e && !busy;
  assign bus.stall_md = busy && hilo_class_d;

endmodule

// File: tb/tb_muldiv_ctl.sv
// Directed scenarios plus random instruction streams against a cycles-remaining model.
module tb_muldiv_ctl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  muldiv_ctl_if bus ();

  muldiv_ctl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // model: cycles of occupancy still to come after the current one (0 = free)
  int rem = 0;
  int cycle_no = 0;
  int base = 0;
  int busy_cnt, stall_cnt, hilo_at;

  function automatic logic [31:0] mk(input logic [5:0] f);
    logic [19:0] mid;
    mid = 20'($urandom);
    return {6'd0, mid, f};
  endfunction

  function automatic logic is_sp(input logic [31:0] i, input logic [5:0] f);
    return (i[31:26] == 6'd0) && (i[5:0] == f);
  endfunction

  function automatic logic is_md(input logic [31:0] i);
    return is_sp(i, 6'h18) || is_sp(i, 6'h19) || is_sp(i, 6'h1A) || is_sp(i, 6'h1B);
  endfunction

  function automatic logic is_hilo(input logic [31:0] i);
    return is_md(i) || is_sp(i, 6'h10) || is_sp(i, 6'h11) || is_sp(i, 6'h12) || is_sp(i, 6'h13);
  endfunction

  function automatic logic [1:0] op_code(input logic [31:0] i);
    case (i[5:0])
      6'h18:   return 2'b00;
      6'h19:   return 2'b01;
      6'h1A:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle_no, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".md_start"}, 32'(bus.md_start), 32'd0);
    check({tag, ".md_op"},    32'(bus.md_op),    32'd0);
    check({tag, ".md_busy"},  32'(bus.md_busy),  32'd0);
    check({tag, ".hilo_we"},  32'(bus.hilo_we),  32'd0);
    check({tag, ".mthi_we"},  32'(bus.mthi_we),  32'd0);
    check({tag, ".mtlo_we"},  32'(bus.mtlo_we),  32'd0);
    check({tag, ".stall_md"}, 32'(bus.stall_md), 32'd0);
  endtask

  task automatic cyc(input logic [31:0] d, input logic [31:0] e, input logic en);
    logic st, bz, hw, thi, tlo, sl;
    logic [1:0] op;
    bus.instrD = d;
    bus.instrE = e;
    bus.enE    = en;
    @(negedge clk);
    st  = rst_n && en && is_md(e) && (rem == 0);
    op  = st ? op_code(e) : 2'b00;
    bz  = rst_n && (st || rem > 0);
    hw  = rst_n && (rem == 1);
    thi = rst_n && en && is_sp(e, 6'h11) && !bz;
    tlo = rst_n && en && is_sp(e, 6'h13) && !bz;
    sl  = bz && is_hilo(d);
    check("md_start", 32'(bus.md_start), 32'(st));
    check("md_op",    32'(bus.md_op),    32'(op));
    check("md_busy",  32'(bus.md_busy),  32'(bz));
    check("hilo_we",  32'(bus.hilo_we),  32'(hw));
    check("mthi_we",  32'(bus.mthi_we),  32'(thi));
    check("mtlo_we",  32'(bus.mtlo_we),  32'(tlo));
    check("stall_md", 32'(bus.stall_md), 32'(sl));
    if (bus.md_busy)  busy_cnt++;
    if (bus.stall_md) stall_cnt++;
    if (bus.hilo_we)  hilo_at = cycle_no - base;
    @(posedge clk);
    if (!rst_n)       rem = 0;
    else if (rem > 0) rem = rem - 1;
    else if (st)      rem = (e[5:0] == 6'h18 || e[5:0] == 6'h19) ? MULT_N : DIV_N;
    #1;
    cycle_no++;
  endtask

  task automatic scen_begin();
    base = cycle_no;
    busy_cnt = 0;
    stall_cnt = 0;
    hilo_at = -1;
  endtask

  logic [31:0] r_d, r_e;

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    case ($urandom_range(0, 11))
      0:  return mk(6'h18);
      1:  return mk(6'h19);
      2:  return mk(6'h1A);
      3:  return mk(6'h1B);
      4:  return mk(6'h10);
      5:  return mk(6'h11);
      6:  return mk(6'h12);
      7:  return mk(6'h13);
      8:  return mk(6'h21);
      9:  return 32'd0;
      10: begin w = mk(6'h18); w[31:26] = 6'h23; return w; end
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.instrD = mk(6'h12);
    bus.instrE = mk(6'h18);
    bus.enE    = 1'b1;
    #3;
    check_all_zero("reset_hold");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // mult, default latency
    scen_begin();
    cyc(32'd0, mk(6'h18), 1'b1);
    for (int i = 0; i < 7; i++) cyc(32'd0, 32'd0, 1'b1);
    check("mult.busy_cycles", 32'(busy_cnt), 32'd6);
    check("mult.hilo_cycle",  32'(hilo_at),  32'd5);

    // divu with mflo waiting in D
    scen_begin();
    cyc(32'd0, mk(6'h1B), 1'b1);
    for (int i = 0; i < 12; i++) cyc(mk(6'h12), 32'd0, 1'b1);
    check("divu.stall_cycles", 32'(stall_cnt), 32'd10);
    check("divu.hilo_cycle",   32'(hilo_at),   32'd10);

    // unrelated D instruction never stalls
    scen_begin();
    cyc(32'd0, mk(6'h18), 1'b1);
    for (int i = 0; i < 6; i++) cyc(mk(6'h21), 32'd0, 1'b1);
    check("addu.stall_cycles", 32'(stall_cnt), 32'd0);

    // mthi idle, then mthi/mult while busy must not disturb the countdown
    cyc(32'd0, mk(6'h11), 1'b1);
    cyc(32'd0, mk(6'h13), 1'b1);
    scen_begin();
    cyc(32'd0, mk(6'h19), 1'b1);
    cyc(32'd0, mk(6'h11), 1'b1);
    cyc(32'd0, mk(6'h1A), 1'b1);
    cyc(32'd0, mk(6'h13), 1'b1);
    for (int i = 0; i < 4; i++) cyc(32'd0, 32'd0, 1'b1);
    check("busy_mthi.hilo_cycle", 32'(hilo_at), 32'd5);

    // reset mid-divide
    scen_begin();
    cyc(32'd0, mk(6'h1A), 1'b1);
    for (int i = 0; i < 3; i++) cyc(mk(6'h10), 32'd0, 1'b1);
    bus.instrD = mk(6'h12);
    bus.instrE = mk(6'h18);
    rst_n = 1'b0;
    rem = 0;
    #1;
    check_all_zero("reset_mid");
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) cyc(mk(6'h12), mk(6'h18), 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(mk(6'h12), 32'd0, 1'b1);
    check("reset_mid.no_hilo", 32'(hilo_at), 32'hFFFF_FFFF);
    scen_begin();
    cyc(32'd0, mk(6'h18), 1'b1);
    for (int i = 0; i < 6; i++) cyc(32'd0, 32'd0, 1'b1);
    check("post_reset.hilo_cycle", 32'(hilo_at), 32'd5);

    // bubble carrying a mult
    scen_begin();
    cyc(32'd0, mk(6'h18), 1'b0);
    cyc(mk(6'h10), 32'd0, 1'b1);
    check("bubble.busy_cycles", 32'(busy_cnt), 32'd0);

    // random streams, mostly valid E
    for (int i = 0; i < 600; i++) begin
      r_d = rand_instr();
      r_e = rand_instr();
      cyc(r_d, r_e, ($urandom_range(0, 7) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctl.md
MULDIV_CTL -- requirements
Module: muldiv_ctl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: execution cycles for mult/multu, legal range 1..15.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: execution cycles for div/divu, legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port instrD, input, 32 bits: instruction in the D stage.
REQ-006 SHALL have port instrE, input, 32 bits: instruction in the E stage.
REQ-007 SHALL have port enE, input, 1 bit: 1 = instrE is valid; 0 = instrE is a bubble.
REQ-008 SHALL have port md_start, output, 1 bit: start pulse to the iterative HI/LO unit.
REQ-009 SHALL have port md_op, output, 2 bits: 00 mult, 01 multu, 10 div, 11 divu.
REQ-010 SHALL have port md_busy, output, 1 bit: unit occupied.
REQ-011 SHALL have port hilo_we, output, 1 bit: commits the unit result to HI and LO.
REQ-012 SHALL have port mthi_we, output, 1 bit: write HI from the rs operand.
REQ-013 SHALL have port mtlo_we, output, 1 bit: write LO from the rs operand.
REQ-014 SHALL have port stall_md, output, 1 bit: stall request for the D stage.

Function
REQ-015 SHALL decode an instruction as SPECIAL when opcode [31:26] = 0; within SPECIAL, funct [5:0] decodes as: mult 0x18, multu 0x19, div 0x1A, divu 0x1B, mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13.
REQ-016 SHALL classify mult, multu, div and divu as "md_op class", and all eight funct codes in REQ-015 as "hilo class".
REQ-017 SHALL implement a two-state FSM, IDLE and BUSY, with a 4-bit down-counter cnt.
REQ-018 SHALL assert md_start combinationally when state = IDLE, enE = 1 and instrE is md_op class.
REQ-019 SHALL drive md_op from funct[1:0] of instrE; md_op SHALL be 00 whenever md_start = 0.
REQ-020 SHALL, on an md_start cycle t, load cnt with MULT_CYCLES-1 (mult class) or DIV_CYCLES-1 (div class) and enter BUSY at t+1.
REQ-021 SHALL, in BUSY with cnt != 0, decrement cnt by 1 each cycle.
REQ-022 SHALL, in BUSY with cnt = 0, assert hilo_we for exactly that one cycle and return to IDLE. Result: for a start at cycle t with N cycles, hilo_we occurs at cycle t+N.
REQ-023 SHALL drive md_busy = md_start OR (state = BUSY), so md_busy is high for cycles t..t+N inclusive.
REQ-024 SHALL drive stall_md = md_busy AND (instrD is hilo class); stall_md SHALL be 0 for all other D instructions, including when instrD = 0.
REQ-025 SHALL assert mthi_we (mtlo_we) combinationally when enE = 1, instrE = mthi (mtlo) and md_busy = 0.
REQ-026 SHALL ignore an md_op class or mthi/mtlo instrE while in BUSY (protocol violation): no start, no *_we, cnt undisturbed.
REQ-027 SHALL ignore instrE when enE = 0.
REQ-028 SHALL NOT start a new operation in the hilo_we cycle; the earliest next md_start is cycle t+N+1.
REQ-029 SHALL ignore operand values; divide-by-zero has no effect on sequencing.

Reset
REQ-030 SHALL, while rst_n = 0 (asynchronously), force state = IDLE and cnt = 0.
REQ-031 SHALL, while rst_n = 0, force md_start, md_op, md_busy, hilo_we, mthi_we, mtlo_we and stall_md all to 0.
REQ-032 SHALL, on reset assertion mid-operation, abort the operation with no hilo_we; the first start after reset release SHALL behave as from a fresh IDLE.

Verification
REQ-033 Scenario: enE = 1, instrE = mult at cycle 0, default parameters. Required response: md_start = 1 with md_op = 00 at cycle 0; md_busy high cycles 0..5; hilo_we high only at cycle 5.
REQ-034 Scenario: instrE = divu at cycle 0, then instrD = mflo during cycles 1..12. Required response: md_op = 11; stall_md high cycles 1..10; hilo_we at cycle 10; stall_md = 0 at cycle 11.
REQ-035 Scenario: mult started at cycle 0, then instrD = addu (funct 0x21) during busy. Required response: stall_md = 0 throughout.
REQ-036 Scenario: mthi in E while IDLE; then mthi in E while BUSY. Required response: mthi_we = 1 in the first case; mthi_we = 0 and cnt unchanged in the second.
REQ-037 Scenario: div started at cycle 0, rst_n pulled low at cycle 4. Required response: all outputs 0 immediately; no hilo_we ever issued; a mult after reset release completes in 5 cycles.
REQ-038 Scenario: instrE = mult with enE = 0. Required response: md_start = 0 and state stays IDLE.
